dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arb_pkg.sv | 24 ++
 rtl/dmem_arb_sel.sv | 48 ++++
 rtl/dmem_arbiter.sv | 124 ++++++++++++
 tb/tb_dmem_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the D-memory arbiter (state encoding, owner ID, bus widths).
// Combinational helpers only; no latency or backpressure of its own.
package dmem_arb_pkg;

  localparam int AWIDTH_DEF = 12;
  localparam int DWIDTH_DEF = 32;
  localparam int BEWIDTH    = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_M0 = 1'b0,
    OWN_M1 = 1'b1
  } owner_t;

  function automatic owner_t other_owner(input owner_t o);
    return (o == OWN_M0) ? OWN_M1 : OWN_M0;
  endfunction

endpackage

// File: rtl/dmem_arb_sel.sv
// Winner selection for two masters; zero latency. A loser simply sees no grant and must hold its request.
// DMEM_ARB_RR_EN: ties follow a toggling pointer, otherwise M0 always wins a tie.
module dmem_arb_sel
  import dmem_arb_pkg::*;
(
`ifdef DMEM_ARB_RR_EN
  input  logic   CLK,
  input  logic   RSTn,
`endif
  input  logic   gnt_en,
  input  logic   req0,
  input  logic   req1,
  output logic   gnt0,
  output logic   gnt1,
  output owner_t winner
);

  owner_t tie_owner;

`ifdef DMEM_ARB_RR_EN
  owner_t ptr_q;

  // After any grant the pointer favours the master that did not win.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      ptr_q <= OWN_M0;
    end else if (gnt0 || gnt1) begin
      ptr_q <= other_owner(winner);
    end
  end

  assign tie_owner = ptr_q;
`else
  assign tie_owner = OWN_M0;
`endif

  always_comb begin
    winner = OWN_M0;
    if (req0 && req1) begin
      winner = tie_owner;
    end else if (req1) begin
      winner = OWN_M1;
    end
    gnt0 = gnt_en && req0 && (winner == OWN_M0);
    gnt1 = gnt_en && req1 && (winner == OWN_M1);
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master single-port SRAM arbiter: read GNT->RVALID 2 cycles, write GNT->SRAM edge 1 cycle, one access per 2 cycles.
// Backpressure by withholding GNT; optional round-robin tie-break with macro DMEM_ARB_RR_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AWIDTH = AWIDTH_DEF,
  parameter int DWIDTH = DWIDTH_DEF
) (
  input  logic               CLK,
  input  logic               RSTn,
  input  logic               M0_REQ,
  input  logic               M0_WEN,
  input  logic [BEWIDTH-1:0] M0_BE,
  input  logic [AWIDTH-1:0]  M0_ADDR,
  input  logic [DWIDTH-1:0]  M0_WDATA,
  output logic               M0_GNT,
  output logic               M0_RVALID,
  output logic [DWIDTH-1:0]  M0_RDATA,
  input  logic               M1_REQ,
  input  logic               M1_WEN,
  input  logic [BEWIDTH-1:0] M1_BE,
  input  logic [AWIDTH-1:0]  M1_ADDR,
  input  logic [DWIDTH-1:0]  M1_WDATA,
  output logic               M1_GNT,
  output logic               M1_RVALID,
  output logic [DWIDTH-1:0]  M1_RDATA,
  output logic               MEM_CSN,
  output logic               MEM_WEN,
  output logic [BEWIDTH-1:0] MEM_BE,
  output logic [AWIDTH-1:0]  MEM_ADDR,
  output logic [DWIDTH-1:0]  MEM_DOUT,
  input  logic [DWIDTH-1:0]  MEM_DI
);

  state_t              state_q, state_d;
  logic                cmd_wen;
  logic [BEWIDTH-1:0]  cmd_be;
  logic [AWIDTH-1:0]   cmd_addr;
  logic [DWIDTH-1:0]   cmd_wdata;
  owner_t              cmd_owner;

  logic                gnt_en, gnt0, gnt1, any_gnt;
  owner_t              winner;

  // Gating with RSTn keeps the combinational grant low while reset is held.
  assign gnt_en  = RSTn && (state_q != ACCESS);
  assign any_gnt = gnt0 || gnt1;
  assign M0_GNT  = gnt0;
  assign M1_GNT  = gnt1;

  dmem_arb_sel u_sel (
`ifdef DMEM_ARB_RR_EN
    .CLK    (CLK),
    .RSTn   (RSTn),
`endif
    .gnt_en (gnt_en),
    .req0   (M0_REQ),
    .req1   (M1_REQ),
    .gnt0   (gnt0),
    .gnt1   (gnt1),
    .winner (winner)
  );

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, RESP: state_d = any_gnt ? ACCESS : IDLE;
      ACCESS:     state_d = cmd_wen ? RESP : IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      cmd_wen   <= 1'b1;
      cmd_be    <= '0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      cmd_owner <= OWN_M0;
    end else if (any_gnt) begin
      cmd_owner <= winner;
      if (winner == OWN_M0) begin
        cmd_wen   <= M0_WEN;
        cmd_be    <= M0_BE;
        cmd_addr  <= M0_ADDR;
        cmd_wdata <= M0_WDATA;
      end else begin
        cmd_wen   <= M1_WEN;
        cmd_be    <= M1_BE;
        cmd_addr  <= M1_ADDR;
        cmd_wdata <= M1_WDATA;
      end
    end
  end

  // Address and data follow the command registers; only CSN/WEN/BE qualify the access.
  always_comb begin
    MEM_CSN = 1'b1;
    MEM_WEN = 1'b1;
    MEM_BE  = '0;
    if (state_q == ACCESS) begin
      MEM_CSN = 1'b0;
      MEM_WEN = cmd_wen;
      MEM_BE  = cmd_be;
    end
  end

  assign MEM_ADDR = cmd_addr;
  assign MEM_DOUT = cmd_wdata;

  assign M0_RVALID = (state_q == RESP) && (cmd_owner == OWN_M0);
  assign M1_RVALID = (state_q == RESP) && (cmd_owner == OWN_M1);
  assign M0_RDATA  = M0_RVALID ? MEM_DI : '0;
  assign M1_RDATA  = M1_RVALID ? MEM_DI : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus a randomized phase against a cycle-count reference model.
module tb_dmem_arbiter;

  localparam int AW = 12;
  localparam int DW = 32;

  logic CLK = 1'b0;
  logic RSTn = 1'b0;
  always #5 CLK = ~CLK;

  logic          m0_req, m0_wen, m1_req, m1_wen;
  logic [3:0]    m0_be, m1_be;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          mem_csn, mem_wen;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_dout;
  logic [DW-1:0] mem_di;

  dmem_arbiter #(.AWIDTH(AW), .DWIDTH(DW)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .M0_REQ(m0_req), .M0_WEN(m0_wen), .M0_BE(m0_be), .M0_ADDR(m0_addr), .M0_WDATA(m0_wdata),
    .M0_GNT(m0_gnt), .M0_RVALID(m0_rvalid), .M0_RDATA(m0_rdata),
    .M1_REQ(m1_req), .M1_WEN(m1_wen), .M1_BE(m1_be), .M1_ADDR(m1_addr), .M1_WDATA(m1_wdata),
    .M1_GNT(m1_gnt), .M1_RVALID(m1_rvalid), .M1_RDATA(m1_rdata),
    .MEM_CSN(mem_csn), .MEM_WEN(mem_wen), .MEM_BE(mem_be), .MEM_ADDR(mem_addr),
    .MEM_DOUT(mem_dout), .MEM_DI(mem_di)
  );

  function automatic logic [31:0] init_pat(input int a);
    return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] be, input logic [31:0] wd);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // Synchronous SRAM: write on the edge, read data on MEM_DI the cycle after.
  logic [31:0] sram [int];
  always @(posedge CLK) begin : sram_p
    int a;
    logic [31:0] cur;
    if (!mem_csn) begin
      a = int'(mem_addr);
      cur = sram.exists(a) ? sram[a] : init_pat(a);
      if (!mem_wen) sram[a] = merge(cur, mem_be, mem_dout);
      else mem_di <= cur;
    end
  end

  // Reference memory as seen by completed accesses.
  logic [31:0] mdl [int];
  function automatic logic [31:0] mdl_rd(input int a);
    return mdl.exists(a) ? mdl[a] : init_pat(a);
  endfunction

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic mid();
    @(negedge CLK);
  endtask

  task automatic idle_in();
    m0_req = 0; m0_wen = 1; m0_be = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_wen = 1; m1_be = 0; m1_addr = 0; m1_wdata = 0;
  endtask

  task automatic set_m(input int m, input logic req, input logic wen, input logic [3:0] be,
                       input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    if (m == 0) begin
      m0_req = req; m0_wen = wen; m0_be = be; m0_addr = addr; m0_wdata = wd;
    end else begin
      m1_req = req; m1_wen = wen; m1_be = be; m1_addr = addr; m1_wdata = wd;
    end
  endtask

  function automatic logic gnt_of(input int m);
    return (m == 0) ? m0_gnt : m1_gnt;
  endfunction

  function automatic logic rv_of(input int m);
    return (m == 0) ? m0_rvalid : m1_rvalid;
  endfunction

  // One complete access; returns read data and how many cycles the grant took.
  task automatic do_access(input int m, input logic wen, input logic [3:0] be, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wd, output logic [DW-1:0] rd, output int waited);
    rd = '0;
    waited = 0;
    set_m(m, 1'b1, wen, be, addr, wd);
    mid();
    while (!gnt_of(m) && waited < 20) begin
      tick();
      mid();
      waited++;
    end
    check("acc_gnt", 64'(gnt_of(m)), 64'(1'b1));
    tick();
    set_m(m, 1'b0, wen, be, addr, wd);
    mid();
    check("acc_csn", 64'(mem_csn), 64'(1'b0));
    check("acc_addr", 64'(mem_addr), 64'(addr));
    if (wen) begin
      tick();
      mid();
      check("acc_rvalid", 64'(rv_of(m)), 64'(1'b1));
      check("acc_other_rvalid", 64'(rv_of(1 - m)), 64'(1'b0));
      rd = (m == 0) ? m0_rdata : m1_rdata;
    end
    tick();
  endtask

  typedef struct packed {
    logic          vld;
    logic          own;
    logic          wen;
    logic [3:0]    be;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    logic [DW-1:0] rd;
  } acc_t;

`ifdef DMEM_ARB_RR_EN
  int rr_ptr;
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] rd;
    int waited, w, got;
    int order[$];
    int gcyc[$];
    acc_t g1, g2, nw;

    // Reset values, with both requests raised to prove GNT is held off.
    idle_in();
    m0_req = 1; m1_req = 1;
    repeat (2) @(posedge CLK);
    mid();
    check("rst_csn", 64'(mem_csn), 64'(1'b1));
    check("rst_wen", 64'(mem_wen), 64'(1'b1));
    check("rst_be", 64'(mem_be), 64'(4'h0));
    check("rst_addr", 64'(mem_addr), 64'(12'h0));
    check("rst_dout", 64'(mem_dout), 64'(32'h0));
    check("rst_gnt", 64'({m0_gnt, m1_gnt}), 64'(2'b00));
    check("rst_rvalid", 64'({m0_rvalid, m1_rvalid}), 64'(2'b00));
    check("rst_rdata", 64'({m0_rdata, m1_rdata}), 64'(0));
    @(posedge CLK);
    #1;
    idle_in();
    RSTn = 1;

    // Write then read back on M0; the write takes the very first cycle after reset.
    do_access(0, 1'b0, 4'hF, 12'h010, 32'hDEAD_BEEF, rd, waited);
    check("first_gnt_wait", 64'(waited), 64'(0));
    do_access(0, 1'b1, 4'h0, 12'h010, 32'h0, rd, waited);
    check("m0_readback", 64'(rd), 64'(32'hDEAD_BEEF));

    // Partial write by M1.
    do_access(1, 1'b0, 4'hF, 12'h020, 32'hFFFF_FFFF, rd, waited);
    do_access(1, 1'b0, 4'h3, 12'h020, 32'h0000_ABCD, rd, waited);
    do_access(1, 1'b1, 4'h0, 12'h020, 32'h0, rd, waited);
    check("m1_partial", 64'(rd), 64'(32'hFFFF_ABCD));

    // Both masters read continuously; record the grant order.
    set_m(0, 1'b1, 1'b1, 4'h0, 12'h010, 32'h0);
    set_m(1, 1'b1, 1'b1, 4'h0, 12'h020, 32'h0);
    for (int c = 0; c < 12; c++) begin
      mid();
      if (m0_gnt) begin order.push_back(0); gcyc.push_back(c); end
      if (m1_gnt) begin order.push_back(1); gcyc.push_back(c); end
      if (order.size() >= 4) break;
      tick();
    end
    tick();
    idle_in();
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      got = (i < order.size()) ? order[i] : -1;
`ifdef DMEM_ARB_RR_EN
      check("tie_order", 64'(got), 64'(i % 2));
`else
      check("tie_order", 64'(got), 64'(0));
`endif
    end
    check("tie_spacing", 64'((gcyc.size() == 4) ? gcyc[3] - gcyc[0] : -1), 64'(6));

    // Back-to-back M0 reads: grants every 2 cycles, data with the next grant.
    set_m(0, 1'b1, 1'b1, 4'h0, 12'h010, 32'h0);
    for (int c = 0; c < 7; c++) begin
      mid();
      check("b2b_gnt", 64'(m0_gnt), 64'(c % 2 == 0));
      check("b2b_rvalid", 64'(m0_rvalid), 64'(c >= 2 && c % 2 == 0));
      check("b2b_m1_rvalid", 64'(m1_rvalid), 64'(1'b0));
      if (c >= 2 && c % 2 == 0) check("b2b_rdata", 64'(m0_rdata), 64'(32'hDEAD_BEEF));
      tick();
    end
    idle_in();
    tick();
    tick();

    // M1 pulses a request only while the M0 write is in ACCESS.
    set_m(0, 1'b1, 1'b0, 4'hF, 12'h030, 32'h1234_5678);
    mid();
    check("pulse_m0_gnt", 64'(m0_gnt), 64'(1'b1));
    tick();
    idle_in();
    set_m(1, 1'b1, 1'b1, 4'h0, 12'h040, 32'h0);
    mid();
    check("pulse_m1_gnt_access", 64'(m1_gnt), 64'(1'b0));
    check("pulse_access_addr", 64'(mem_addr), 64'(12'h030));
    tick();
    idle_in();
    mid();
    check("pulse_m1_gnt_after", 64'(m1_gnt), 64'(1'b0));
    check("pulse_csn_after", 64'(mem_csn), 64'(1'b1));
    tick();
    mid();
    check("pulse_csn_later", 64'(mem_csn), 64'(1'b1));
    check("pulse_m1_rvalid", 64'(m1_rvalid), 64'(1'b0));
    tick();

    // Reset in the middle of a read ACCESS.
    set_m(0, 1'b1, 1'b1, 4'h0, 12'h010, 32'h0);
    mid();
    check("rstmid_gnt", 64'(m0_gnt), 64'(1'b1));
    tick();
    RSTn = 0;
    #1;
    check("rstmid_csn", 64'(mem_csn), 64'(1'b1));
    check("rstmid_addr", 64'(mem_addr), 64'(12'h0));
    mid();
    check("rstmid_rvalid", 64'(m0_rvalid), 64'(1'b0));
    tick();
    mid();
    check("rstmid_rvalid2", 64'(m0_rvalid), 64'(1'b0));
    check("rstmid_gnt_held", 64'(m0_gnt), 64'(1'b0));
    tick();
    RSTn = 1;
    mid();
    check("rstmid_first_gnt", 64'(m0_gnt), 64'(1'b1));
    check("rstmid_rvalid3", 64'(m0_rvalid), 64'(1'b0));
    tick();
    idle_in();
    mid();
    check("rstmid_access", 64'(mem_csn), 64'(1'b0));
    tick();
    mid();
    check("rstmid_new_rvalid", 64'(m0_rvalid), 64'(1'b1));
    check("rstmid_new_rdata", 64'(m0_rdata), 64'(32'hDEAD_BEEF));
    tick();

    // Randomized traffic: a grant blocks the next cycle, a read returns two cycles after its grant.
    RSTn = 0;
    tick();
    tick();
    RSTn = 1;
`ifdef DMEM_ARB_RR_EN
    rr_ptr = 0;
`endif
    g1 = '0;
    g2 = '0;
    for (int c = 0; c < 400; c++) begin
      m0_req = 1'($urandom_range(0, 9) < 6); m0_wen = 1'($urandom); m0_be = 4'($urandom);
      m0_addr = 12'h100 + 12'(4 * $urandom_range(0, 7)); m0_wdata = $urandom;
      m1_req = 1'($urandom_range(0, 9) < 6); m1_wen = 1'($urandom); m1_be = 4'($urandom);
      m1_addr = 12'h100 + 12'(4 * $urandom_range(0, 7)); m1_wdata = $urandom;
      mid();
      w = -1;
      if (!g1.vld) begin
        if (m0_req && m1_req) begin
`ifdef DMEM_ARB_RR_EN
          w = rr_ptr;
`else
          w = 0;
`endif
        end else if (m0_req) w = 0;
        else if (m1_req) w = 1;
      end
      check("rnd_gnt0", 64'(m0_gnt), 64'(w == 0));
      check("rnd_gnt1", 64'(m1_gnt), 64'(w == 1));
      check("rnd_csn", 64'(mem_csn), 64'(!g1.vld));
      if (g1.vld) begin
        check("rnd_mem_wen", 64'(mem_wen), 64'(g1.wen));
        check("rnd_mem_addr", 64'(mem_addr), 64'(g1.addr));
        if (!g1.wen) begin
          check("rnd_mem_be", 64'(mem_be), 64'(g1.be));
          check("rnd_mem_dout", 64'(mem_dout), 64'(g1.wd));
        end
      end
      check("rnd_rvalid0", 64'(m0_rvalid), 64'(g2.vld && g2.wen && g2.own == 1'b0));
      check("rnd_rvalid1", 64'(m1_rvalid), 64'(g2.vld && g2.wen && g2.own == 1'b1));
      if (g2.vld && g2.wen)
        check("rnd_rdata", 64'(g2.own ? m1_rdata : m0_rdata), 64'(g2.rd));
      nw = '0;
      if (w >= 0) begin
        nw.vld  = 1'b1;
        nw.own  = 1'(w);
        nw.wen  = (w == 0) ? m0_wen : m1_wen;
        nw.be   = (w == 0) ? m0_be : m1_be;
        nw.addr = (w == 0) ? m0_addr : m1_addr;
        nw.wd   = (w == 0) ? m0_wdata : m1_wdata;
        if (nw.wen) nw.rd = mdl_rd(int'(nw.addr));
        else mdl[int'(nw.addr)] = merge(mdl_rd(int'(nw.addr)), nw.be, nw.wd);
`ifdef DMEM_ARB_RR_EN
        rr_ptr = 1 - w;
`endif
      end
      g2 = g1;
      g1 = nw;
      tick();
    end
    idle_in();
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
